// File: rtl/serial_receiver_cfg_pkg.sv
// Shared types for the configurable UART receiver: width aliases, parity mode
// and the one-hot receive state encoding.
package serial_receiver_cfg_pkg;

    typedef logic [7:0]  u8;
    typedef logic [15:0] u16;
    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_BREAK  = 6'b100000
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_receiver_cfg_fifo.sv
// First-word-fall-through fifo holding received words; the head word is on
// dout_o whenever the fifo is not empty, and dout_o reads 0 when empty.
module serial_receiver_cfg_fifo #(
    parameter  int unsigned WIDTH = 10,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_rd   = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a write to a full fifo still lands.
    assign do_wr   = wr_en_i && (!full_o || do_rd);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            count_q <= count_d;
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; pointers and count define validity, keeping it mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/serial_receiver_cfg.sv
// Configurable UART receiver: synchronised, oversampled and majority-voted RX,
// runtime-fixed frame format, received words with error flags buffered in a fifo.
module serial_receiver_cfg
    import serial_receiver_cfg_pkg::*;
#(
    parameter  int unsigned CLK_IN     = 0,
    parameter  int unsigned BAUD       = 0,
    parameter  int unsigned OVERSAMPLE = 16,
    parameter  int unsigned DATA_BITS  = 8,
    parameter  int unsigned PARITY     = 0,
    parameter  int unsigned STOP_BITS  = 1,
    parameter  int unsigned DEPTH      = 512,
    localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_perr,
    output logic                 dout_ferr,
    output logic                 empty,
    output logic                 full,
    output logic [CW-1:0]        data_count,
    output logic                 overrun,
    input  logic                 err_clr
);

    localparam int unsigned DENOM = (BAUD * OVERSAMPLE == 0) ? 1 : BAUD * OVERSAMPLE;
    localparam int unsigned DIV   = CLK_IN / DENOM;
    localparam int unsigned DW    = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned SW    = $clog2(OVERSAMPLE);
    localparam int unsigned BW    = $clog2(DATA_BITS + 1);
    localparam int unsigned FW    = DATA_BITS + 2;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_DONE = BW'(DATA_BITS);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam parity_e       PAR_MODE  = parity_e'(PARITY[1:0]);
    localparam logic          PAR_XOR   = (PAR_MODE == PAR_ODD);

    if (CLK_IN == 0 || BAUD == 0 || DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("serial_receiver_cfg: parameter set out of range");
    end

    rx_state_e            state_q;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 rx_prev_q;
    logic [DW-1:0]        div_q;
    logic [DW-1:0]        div_d;
    logic [SW-1:0]        s_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 v_lo_q;
    logic                 v_mid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 push_q;
    logic [FW-1:0]        word_q;
    logic                 overrun_q;
    logic                 overrun_d;
    logic                 tick;
    logic                 decide;
    logic                 wrap;
    logic                 maj;
    logic [FW-1:0]        fifo_dout;

    assign rx_s   = sync_q[1];
    assign tick   = (state_q != ST_IDLE) && (div_q == DIV_LAST);
    assign decide = tick && (s_q == S_HI);
    assign wrap   = tick && (s_q == S_LAST);
    assign maj    = majority3(v_lo_q, v_mid_q, rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], RX};
            rx_prev_q <= rx_s;
        end
    end

    // The divider idles at 0 so the first tick of a frame is a full period after the edge.
    always_comb begin
        div_d = div_q + 1'b1;
        if (state_q == ST_IDLE || tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            v_lo_q     <= 1'b1;
            v_mid_q    <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            push_q     <= 1'b0;
            word_q     <= '0;
        end else begin
            push_q <= 1'b0;
            if (tick) begin
                s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
                if (s_q == S_LO) v_lo_q <= rx_s;
                if (s_q == S_MID) v_mid_q <= rx_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q    <= ST_START;
                        s_q        <= '0;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide && maj) begin
                        state_q <= ST_IDLE;
                    end else if (wrap) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shift_q   <= {maj, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    if (wrap && bit_cnt_q == BITS_DONE) begin
                        state_q <= (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        perr_q <= ((^shift_q) ^ maj) != PAR_XOR;
                    end
                    if (wrap) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        if (!maj) ferr_q <= 1'b1;
                        // Push at mid-stop so a start edge half a bit later is still caught.
                        if (stop_cnt_q == STOP_LAST) begin
                            push_q  <= 1'b1;
                            word_q  <= {perr_q, ferr_q | ~maj, shift_q};
                            state_q <= maj ? ST_IDLE : ST_BREAK;
                        end
                    end
                    if (wrap) begin
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (push_q && full && !rd_en) overrun_d = 1'b1;
        if (err_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;

    serial_receiver_cfg_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (push_q),
        .din_i   (word_q),
        .rd_en_i (rd_en),
        .dout_o  (fifo_dout),
        .empty_o (empty),
        .full_o  (full),
        .count_o (data_count)
    );

    assign dout      = fifo_dout[DATA_BITS-1:0];
    assign dout_ferr = fifo_dout[DATA_BITS];
    assign dout_perr = fifo_dout[DATA_BITS+1];

endmodule

// File: tb/tb_serial_receiver_cfg.sv
// Bench for serial_receiver_cfg: three instances (8N1 depth 4, 7E1, 8N2) driven
// with bit-accurate frames; expected words go through a scoreboard queue.
module tb_serial_receiver_cfg;
    import serial_receiver_cfg_pkg::*;

    localparam int BIT_CLK = 32;

    typedef struct {
        int   inst;
        u8    data;
        bit   bad_par;
        bit [1:0] stops;
        u8    exp_data;
        logic exp_perr;
        logic exp_ferr;
        string name;
    } vec_t;

    typedef struct {
        int    inst;
        u8     data;
        logic  perr;
        logic  ferr;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] rx_v;
    logic [2:0] rd_v;
    logic [2:0] clr_v;
    logic [2:0] perr_v, ferr_v, empty_v, full_v, ovr_v;
    u8          dout_a, dout_c;
    logic [6:0] dout_b;
    logic [2:0] cnt_a;
    logic [4:0] cnt_b, cnt_c;
    u8          dout_v [3];
    logic [4:0] cnt_v  [3];

    int   nbits_cfg [3] = '{8, 7, 8};
    int   par_cfg   [3] = '{0, 2, 0};
    int   stop_cfg  [3] = '{1, 1, 2};
    exp_t sb_q [$];
    vec_t vecs [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    assign dout_v[0] = dout_a;
    assign dout_v[1] = {1'b0, dout_b};
    assign dout_v[2] = dout_c;
    assign cnt_v[0]  = {2'b00, cnt_a};
    assign cnt_v[1]  = cnt_b;
    assign cnt_v[2]  = cnt_c;

    serial_receiver_cfg #(.CLK_IN(3_686_400), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                          .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .RX(rx_v[0]), .rd_en(rd_v[0]), .dout(dout_a),
        .dout_perr(perr_v[0]), .dout_ferr(ferr_v[0]), .empty(empty_v[0]), .full(full_v[0]),
        .data_count(cnt_a), .overrun(ovr_v[0]), .err_clr(clr_v[0]));

    serial_receiver_cfg #(.CLK_IN(3_686_400), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(7),
                          .PARITY(2), .STOP_BITS(1), .DEPTH(16)) u_7e1 (
        .clk(clk), .rst(rst), .RX(rx_v[1]), .rd_en(rd_v[1]), .dout(dout_b),
        .dout_perr(perr_v[1]), .dout_ferr(ferr_v[1]), .empty(empty_v[1]), .full(full_v[1]),
        .data_count(cnt_b), .overrun(ovr_v[1]), .err_clr(clr_v[1]));

    serial_receiver_cfg #(.CLK_IN(3_686_400), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                          .PARITY(0), .STOP_BITS(2), .DEPTH(16)) u_8n2 (
        .clk(clk), .rst(rst), .RX(rx_v[2]), .rd_en(rd_v[2]), .dout(dout_c),
        .dout_perr(perr_v[2]), .dout_ferr(ferr_v[2]), .empty(empty_v[2]), .full(full_v[2]),
        .data_count(cnt_c), .overrun(ovr_v[2]), .err_clr(clr_v[2]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input int inst, input logic v);
        rx_v[inst] = v;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    // stops[0] is the first stop bit, stops[1] the second.
    task automatic send_frame(input int inst, input u8 data, input bit bad_par, input bit [1:0] stops);
        logic p;
        p = 1'b0;
        drive_bit(inst, 1'b0);
        for (int i = 0; i < nbits_cfg[inst]; i++) begin
            drive_bit(inst, data[i]);
            p ^= data[i];
        end
        if (par_cfg[inst] != 0) begin
            p = (par_cfg[inst] == 1) ? ~p : p;
            drive_bit(inst, p ^ bad_par);
        end
        for (int i = 0; i < stop_cfg[inst]; i++) begin
            drive_bit(inst, stops[i]);
        end
    endtask

    task automatic expect_word(input int inst, input u8 data, input logic perr, input logic ferr,
                               input string name);
        sb_q.push_back('{inst: inst, data: data, perr: perr, ferr: ferr, name: name});
    endtask

    task automatic drain();
        exp_t e;
        int   waited;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            waited = 0;
            while (empty_v[e.inst] && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            check({e.name, "_avail"}, {31'd0, empty_v[e.inst]}, 32'd0);
            if (!empty_v[e.inst]) begin
                @(negedge clk);
                check({e.name, "_data"}, {24'd0, dout_v[e.inst]}, {24'd0, e.data});
                check({e.name, "_perr"}, {31'd0, perr_v[e.inst]}, {31'd0, e.perr});
                check({e.name, "_ferr"}, {31'd0, ferr_v[e.inst]}, {31'd0, e.ferr});
                rd_v[e.inst] = 1'b1;
                @(negedge clk);
                rd_v[e.inst] = 1'b0;
            end
        end
    endtask

    task automatic add_vec(input int inst, input u8 data, input bit bad_par, input bit [1:0] stops,
                           input u8 exp_data, input logic exp_perr, input logic exp_ferr,
                           input string name);
        vecs.push_back('{inst: inst, data: data, bad_par: bad_par, stops: stops, exp_data: exp_data,
                         exp_perr: exp_perr, exp_ferr: exp_ferr, name: name});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        u8 burst [5];

        add_vec(0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, "v8n1_00");
        add_vec(0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, "v8n1_ff");
        add_vec(1, 8'h41, 1'b1, 2'b11, 8'h41, 1'b1, 1'b0, "v7e1_41_badpar");
        add_vec(1, 8'h41, 1'b0, 2'b11, 8'h41, 1'b0, 1'b0, "v7e1_41_ok");
        add_vec(1, 8'h7E, 1'b0, 2'b11, 8'h7E, 1'b0, 1'b0, "v7e1_7e_ok");
        add_vec(1, 8'h2A, 1'b1, 2'b10, 8'h2A, 1'b1, 1'b1, "v7e1_2a_both");
        add_vec(2, 8'h81, 1'b0, 2'b11, 8'h81, 1'b0, 1'b0, "v8n2_81_ok");
        add_vec(2, 8'h5A, 1'b0, 2'b10, 8'h5A, 1'b0, 1'b1, "v8n2_5a_stop1");

        rst   = 1'b1;
        rx_v  = 3'b111;
        rd_v  = 3'b000;
        clr_v = 3'b000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_empty",   {31'd0, empty_v[i]}, 32'd1);
            check("rst_full",    {31'd0, full_v[i]},  32'd0);
            check("rst_count",   {27'd0, cnt_v[i]},   32'd0);
            check("rst_overrun", {31'd0, ovr_v[i]},   32'd0);
            check("rst_dout",    {24'd0, dout_v[i]},  32'd0);
            check("rst_flags",   {30'd0, perr_v[i], ferr_v[i]}, 32'd0);
        end
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Back-to-back 8N1 frames with no idle gap.
        send_frame(0, 8'hA5, 1'b0, 2'b11);
        expect_word(0, 8'hA5, 1'b0, 1'b0, "t1_a5");
        send_frame(0, 8'h3C, 1'b0, 2'b11);
        expect_word(0, 8'h3C, 1'b0, 1'b0, "t1_3c");
        drain();

        foreach (vecs[k]) begin
            send_frame(vecs[k].inst, vecs[k].data, vecs[k].bad_par, vecs[k].stops);
            expect_word(vecs[k].inst, vecs[k].exp_data, vecs[k].exp_perr, vecs[k].exp_ferr, vecs[k].name);
            rx_v[vecs[k].inst] = 1'b1;
            repeat (2 * BIT_CLK) @(posedge clk);
            drain();
        end

        // 8N2 with second stop low, then line held low for 20 bit times.
        send_frame(2, 8'hC3, 1'b0, 2'b01);
        repeat (20 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        check("t3_one_word", {27'd0, cnt_v[2]}, 32'd1);
        rx_v[2] = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        check("t3_still_one", {27'd0, cnt_v[2]}, 32'd1);
        expect_word(2, 8'hC3, 1'b0, 1'b1, "t3_c3_ferr");
        drain();
        send_frame(2, 8'h18, 1'b0, 2'b11);
        expect_word(2, 8'h18, 1'b0, 1'b0, "t3_after_break");
        drain();

        // Short low glitch while idle.
        @(posedge clk);
        rx_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        rx_v[0] = 1'b1;
        repeat (12 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        check("t4_empty", {31'd0, empty_v[0]}, 32'd1);
        check("t4_count", {27'd0, cnt_v[0]}, 32'd0);
        send_frame(0, 8'h96, 1'b0, 2'b11);
        expect_word(0, 8'h96, 1'b0, 1'b0, "t4_after_glitch");
        drain();

        // Overflow a depth-4 fifo.
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 0; k < 5; k++) begin
            send_frame(0, burst[k], 1'b0, 2'b11);
            if (k < 4) expect_word(0, burst[k], 1'b0, 1'b0, $sformatf("t5_w%0d", k));
        end
        @(negedge clk);
        check("t5_full",    {31'd0, full_v[0]}, 32'd1);
        check("t5_count",   {27'd0, cnt_v[0]},  32'd4);
        check("t5_overrun", {31'd0, ovr_v[0]},  32'd1);
        drain();
        @(negedge clk);
        check("t5_empty_after", {31'd0, empty_v[0]}, 32'd1);
        check("t5_overrun_held", {31'd0, ovr_v[0]}, 32'd1);
        clr_v[0] = 1'b1;
        @(negedge clk);
        clr_v[0] = 1'b0;
        check("t5_overrun_clr", {31'd0, ovr_v[0]}, 32'd0);

        // Refill and overflow again, leave a word in the 7E1 fifo, then reset mid-frame.
        send_frame(1, 8'h12, 1'b0, 2'b11);
        burst = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        for (int k = 0; k < 5; k++) send_frame(0, burst[k], 1'b0, 2'b11);
        @(negedge clk);
        check("t6_pre_overrun", {31'd0, ovr_v[0]}, 32'd1);
        check("t6_pre_b_count", {27'd0, cnt_v[1]}, 32'd1);
        fork
            send_frame(0, 8'hE7, 1'b0, 2'b11);
        join_none
        repeat (5 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
        rst = 1'b1;
        wait fork;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        check("t6_empty",   {31'd0, empty_v[0]}, 32'd1);
        check("t6_full",    {31'd0, full_v[0]},  32'd0);
        check("t6_count",   {27'd0, cnt_v[0]},   32'd0);
        check("t6_overrun", {31'd0, ovr_v[0]},   32'd0);
        check("t6_dout",    {24'd0, dout_v[0]},  32'd0);
        check("t6_b_empty", {31'd0, empty_v[1]}, 32'd1);
        send_frame(0, 8'h55, 1'b0, 2'b11);
        expect_word(0, 8'h55, 1'b0, 1'b0, "t6_55_after_rst");
        drain();
        @(negedge clk);
        check("t6_final_empty", {31'd0, empty_v[0]}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
